// File: rtl/gb_peek_responder_if.sv
// Game Boy memory-bus side of the debug-peek responder.
// Carries the request/grant handshake and the single-read channel.
//   bus_req    : bus request, driven by the responder
//   bus_gnt    : grant from the bus arbiter
//   mem_addr   : read address, driven by the responder
//   mem_rd     : one-cycle read strobe, driven by the responder
//   mem_rdata  : read data from memory
//   mem_rvalid : qualifier for mem_rdata
// The responder connects through the master modport and the memory/arbiter
// side through the slave modport.
interface gb_peek_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output bus_req, mem_addr, mem_rd,
    input  bus_gnt, mem_rdata, mem_rvalid
  );

  modport slave (
    input  bus_req, mem_addr, mem_rd,
    output bus_gnt, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/gb_peek_responder.sv
// Debug-peek responder: debounces the address from the Nios address PIO,
// requests the Game Boy memory bus, performs a single read and holds the byte
// on the Nios data-in PIO until the next address has been serviced. A timeout
// over the REQ+WAIT phases returns all-ones instead of hanging.
//   clk       : sole clock (Game Boy domain)
//   reset     : asynchronous, active-high reset
//   nios_addr : requested address from the Nios address PIO
//   nios_din  : returned byte to the Nios data-in PIO (registered)
//   peek_busy : high while an address is pending or in service (registered)
//   bus       : memory-bus interface (request/grant and read channel)
module gb_peek_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    nios_addr,
  output logic [DATA_W-1:0]    nios_din,
  output logic                 peek_busy,
  gb_peek_responder_if.master  bus
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_REQ    = 3'd2,
    ST_READ   = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] snap_r, snap_s;
  logic [ADDR_W-1:0] svc_addr_r, svc_addr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              init_r, init_s;
  logic [DATA_W-1:0] nios_din_r, nios_din_s;
  logic              peek_busy_r, peek_busy_s;
  logic              bus_req_r, bus_req_s;
  logic              mem_rd_r, mem_rd_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mismatch_s;
  logic              tmo_hit_s;

  // New work exists when the address differs from the last serviced one,
  // or after reset so the current address is always read once.
  assign mismatch_s = (nios_addr != svc_addr_r) || init_r;
  // tmo counts cycles already spent; this cycle would be the TIMEOUT-th one.
  assign tmo_hit_s  = (tmo_r == TMO_W'(TIMEOUT - 1));

  // Next-state and next-register computation for the service FSM.
  always_comb begin
    state_s    = state_r;
    snap_s     = snap_r;
    svc_addr_s = svc_addr_r;
    cnt_s      = cnt_r;
    tmo_s      = tmo_r;
    init_s     = init_r;
    nios_din_s = nios_din_r;
    bus_req_s  = bus_req_r;
    mem_rd_s   = 1'b0;
    mem_addr_s = mem_addr_r;

    case (state_r)
      ST_IDLE: begin
        if (mismatch_s) begin
          snap_s  = nios_addr;
          cnt_s   = CNT_W'(1);
          init_s  = 1'b0;
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (nios_addr != snap_r) begin
          snap_s = nios_addr;
          cnt_s  = CNT_W'(1);
        end else if (cnt_r == CNT_W'(SETTLE)) begin
          tmo_s     = {TMO_W{1'b0}};
          bus_req_s = 1'b1;
          state_s   = ST_REQ;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_REQ: begin
        // Timeout wins over a coincident grant so the REQ+WAIT bound holds.
        if (tmo_hit_s) begin
          nios_din_s = {DATA_W{1'b1}};
          svc_addr_s = snap_r;
          bus_req_s  = 1'b0;
          state_s    = ST_IDLE;
        end else if (bus.bus_gnt) begin
          tmo_s      = tmo_r + TMO_W'(1);
          mem_rd_s   = 1'b1;
          mem_addr_s = snap_r;
          state_s    = ST_READ;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_READ: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // Data arriving on the last allowed cycle is still accepted.
        if (bus.mem_rvalid) begin
          nios_din_s = bus.mem_rdata;
          svc_addr_s = snap_r;
          bus_req_s  = 1'b0;
          state_s    = ST_IDLE;
        end else if (tmo_hit_s) begin
          nios_din_s = {DATA_W{1'b1}};
          svc_addr_s = snap_r;
          bus_req_s  = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      default: begin
        bus_req_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase

    // Busy stays up across a completion whose address has already moved on.
    peek_busy_s = (state_s != ST_IDLE) || init_s || (nios_addr != svc_addr_s);
  end

  // State and output registers; reset drops the bus request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      snap_r      <= {ADDR_W{1'b0}};
      svc_addr_r  <= {ADDR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      init_r      <= 1'b1;
      nios_din_r  <= {DATA_W{1'b1}};
      peek_busy_r <= 1'b0;
      bus_req_r   <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r     <= state_s;
      snap_r      <= snap_s;
      svc_addr_r  <= svc_addr_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      init_r      <= init_s;
      nios_din_r  <= nios_din_s;
      peek_busy_r <= peek_busy_s;
      bus_req_r   <= bus_req_s;
      mem_rd_r    <= mem_rd_s;
      mem_addr_r  <= mem_addr_s;
    end
  end

  assign nios_din     = nios_din_r;
  assign peek_busy    = peek_busy_r;
  assign bus.bus_req  = bus_req_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.mem_addr = mem_addr_r;

endmodule

// File: tb/tb_gb_peek_responder.sv
// Directed testbench for gb_peek_responder: a small memory/arbiter model
// answers reads with a programmable latency, and a linear sequence of steps
// checks outputs against hand-computed values.
module tb_gb_peek_responder;

  logic        clk;
  logic        reset;
  logic [15:0] nios_addr;
  logic [7:0]  nios_din;
  logic        peek_busy;

  int checks = 0;
  int errors = 0;

  int          lat;        // rvalid delay after mem_rd, 0 = never answer
  int          pend_cnt;
  logic [15:0] pend_addr;
  logic [15:0] rd_log[$];  // every mem_rd address, in order

  int base;
  int hi_cnt;
  int rd_cnt;

  gb_peek_responder_if #(.ADDR_W(16), .DATA_W(8)) mem_bus_if ();

  gb_peek_responder #(
    .ADDR_W(16), .DATA_W(8), .SETTLE(2), .TIMEOUT(255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nios_addr (nios_addr),
    .nios_din  (nios_din),
    .peek_busy (peek_busy),
    .bus       (mem_bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h31;
      16'hFF44: return 8'h90;
      16'hC000: return 8'h77;
      16'hC001: return 8'h5A;
      16'h8000: return 8'hA5;
      16'h9800: return 8'h3C;
      16'h4000: return 8'h6B;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: logs strobes and returns data lat cycles after mem_rd.
  initial begin
    pend_cnt = 0;
    pend_addr = 16'h0000;
    mem_bus_if.mem_rvalid = 1'b0;
    mem_bus_if.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      mem_bus_if.mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_bus_if.mem_rvalid = 1'b1;
          mem_bus_if.mem_rdata = mem_byte(pend_addr);
        end
      end
      if (mem_bus_if.mem_rd === 1'b1) begin
        rd_log.push_back(mem_bus_if.mem_addr);
        pend_cnt = lat;
        pend_addr = mem_bus_if.mem_addr;
      end
      if (reset) pend_cnt = 0;
    end
  end

  initial begin
    reset = 1'b1;
    nios_addr = 16'h0000;
    mem_bus_if.bus_gnt = 1'b1;
    lat = 1;
    tick(2);

    // Reset values
    chk("rst_din", 32'(nios_din), 32'hFF);
    chk("rst_busy", 32'(peek_busy), 32'h0);
    chk("rst_req", 32'(mem_bus_if.bus_req), 32'h0);
    chk("rst_rd", 32'(mem_bus_if.mem_rd), 32'h0);
    chk("rst_maddr", 32'(mem_bus_if.mem_addr), 32'h0);

    // Release: init forces a read of 0x0000, grant tied high
    reset = 1'b0;
    tick(1);
    chk("t1_busy", 32'(peek_busy), 32'h1);
    tick(2);
    chk("t1_req", 32'(mem_bus_if.bus_req), 32'h1);
    chk("t1_rd_pre", 32'(mem_bus_if.mem_rd), 32'h0);
    tick(1);
    chk("t1_rd", 32'(mem_bus_if.mem_rd), 32'h1);
    chk("t1_maddr", 32'(mem_bus_if.mem_addr), 32'h0000);
    tick(1);
    chk("t1_rd_one", 32'(mem_bus_if.mem_rd), 32'h0);
    chk("t1_din_hold", 32'(nios_din), 32'hFF);
    tick(1);
    chk("t1_din", 32'(nios_din), 32'h31);
    chk("t1_req_off", 32'(mem_bus_if.bus_req), 32'h0);
    chk("t1_busy_off", 32'(peek_busy), 32'h0);
    chk("t1_nrd", 32'(rd_log.size()), 32'd1);
    tick(3);
    chk("t1_no_retry", 32'(rd_log.size()), 32'd1);

    // 0xFF44 with grant arriving after 10 REQ cycles
    base = rd_log.size();
    mem_bus_if.bus_gnt = 1'b0;
    nios_addr = 16'hFF44;
    hi_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (mem_bus_if.bus_req) hi_cnt++;
      if (i == 12) mem_bus_if.bus_gnt = 1'b1;
    end
    chk("t2_req_cycles", 32'(hi_cnt), 32'd12);
    chk("t2_din", 32'(nios_din), 32'h90);
    chk("t2_nrd", 32'(rd_log.size() - base), 32'd1);
    chk("t2_busy", 32'(peek_busy), 32'h0);

    // Toggling address is debounced to a single read of the final value
    base = rd_log.size();
    for (int i = 0; i < 8; i++) begin
      nios_addr = (i % 2 == 0) ? 16'hC000 : 16'hC001;
      tick(1);
    end
    chk("t3_no_rd_yet", 32'(rd_log.size() - base), 32'd0);
    tick(8);
    chk("t3_nrd", 32'(rd_log.size() - base), 32'd1);
    chk("t3_addr", 32'(rd_log[rd_log.size() - 1]), 32'hC001);
    chk("t3_din", 32'(nios_din), 32'h5A);

    // Address change while in WAIT: old result first, then new address
    base = rd_log.size();
    lat = 3;
    nios_addr = 16'h8000;
    tick(5);
    chk("t4_wait_req", 32'(mem_bus_if.bus_req), 32'h1);
    chk("t4_wait_rd", 32'(mem_bus_if.mem_rd), 32'h0);
    nios_addr = 16'h9800;
    tick(3);
    chk("t4_din_old", 32'(nios_din), 32'hA5);
    chk("t4_busy_mid", 32'(peek_busy), 32'h1);
    tick(8);
    chk("t4_din_new", 32'(nios_din), 32'h3C);
    chk("t4_nrd", 32'(rd_log.size() - base), 32'd2);
    chk("t4_addr0", 32'(rd_log[base]), 32'h8000);
    chk("t4_addr1", 32'(rd_log[base + 1]), 32'h9800);
    chk("t4_busy_end", 32'(peek_busy), 32'h0);

    // Reset while in WAIT, then re-read of the current address
    base = rd_log.size();
    lat = 0;
    nios_addr = 16'h4000;
    tick(5);
    chk("t6_in_wait", 32'(mem_bus_if.bus_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_req_drop", 32'(mem_bus_if.bus_req), 32'h0);
    chk("t6_rd_drop", 32'(mem_bus_if.mem_rd), 32'h0);
    chk("t6_din_rst", 32'(nios_din), 32'hFF);
    chk("t6_busy_rst", 32'(peek_busy), 32'h0);
    lat = 1;
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("t6_din", 32'(nios_din), 32'h6B);
    chk("t6_nrd", 32'(rd_log.size() - base), 32'd2);
    chk("t6_addr", 32'(rd_log[rd_log.size() - 1]), 32'h4000);

    // Grant withheld: timeout after 255 request cycles, no retry
    base = rd_log.size();
    mem_bus_if.bus_gnt = 1'b0;
    nios_addr = 16'h1234;
    hi_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      tick(1);
      if (mem_bus_if.bus_req) hi_cnt++;
    end
    chk("t5_req_cycles", 32'(hi_cnt), 32'd255);
    chk("t5_din", 32'(nios_din), 32'hFF);
    chk("t5_req_off", 32'(mem_bus_if.bus_req), 32'h0);
    chk("t5_busy", 32'(peek_busy), 32'h0);
    chk("t5_nrd", 32'(rd_log.size() - base), 32'd0);
    mem_bus_if.bus_gnt = 1'b1;
    hi_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_bus_if.bus_req) hi_cnt++;
      if (mem_bus_if.mem_rd) rd_cnt++;
    end
    chk("t5_no_retry_req", 32'(hi_cnt), 32'd0);
    chk("t5_no_retry_rd", 32'(rd_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
